multi_bgu: RTL and testbench

MULTI_BGU -- requirements
Module: multi_bgu

---
 rtl/kl_branch_pkg.sv | 19 +
 rtl/branch_lane_decode.sv | 27 ++
 rtl/multi_bgu.sv | 123 ++++++++++++
 tb/tb_multi_bgu.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/kl_branch_pkg.sv
// kl_branch_pkg: shared branch-unit types, opcodes and condition pairing.
package kl_branch_pkg;
    typedef enum logic [2:0] {NV = 3'd0, AL = 3'd1, EQ = 3'd2, NE = 3'd3,
                              LT = 3'd4, LE = 3'd5, GT = 3'd6, GE = 3'd7} cond_t;
    typedef enum logic [2:0] {NONE, COND, UNCOND, CALL, RET} br_class_t;
    typedef struct packed {cond_t c; cond_t n;} cond_pair_t;
    localparam logic [2:0] OP_BCOND = 3'b001;
    localparam logic [2:0] OP_BCALL = 3'b010;
    // instruction condition field -> (condition, complement)
    function automatic cond_pair_t cond_pair(input logic [2:0] f);
        case (f)
            3'd1:    cond_pair = '{EQ, NE};
            3'd2:    cond_pair = '{NE, EQ};
            3'd3:    cond_pair = '{LT, GE};
            3'd4:    cond_pair = '{LE, GT};
            default: cond_pair = '{AL, NV};
        endcase
    endfunction
endpackage

// File: rtl/branch_lane_decode.sv
// branch_lane_decode: classifies one bundle lane and computes its fall-through and target.
module branch_lane_decode import kl_branch_pkg::*; #(
    parameter int PCW = 9,
    parameter int K   = 0
) (
    input  logic [PCW-1:0] pc,
    input  logic [15:0]    ir,
    input  logic           fmt,
    input  logic           valid,
    output br_class_t      cls,
    output logic [PCW-1:0] fall,
    output logic [PCW-1:0] target,
    output logic [2:0]     cond
);
    logic [PCW-1:0] imm;
    logic           unused;
    assign unused = ir[12];
    assign imm    = PCW'(ir[7:0]);
    assign fall   = pc + PCW'(K + 1);
    assign target = fmt ? imm : fall + imm;
    assign cond   = ir[10:8];
    always_comb begin
        cls = !valid ? NONE :
              ir[15:13] == OP_BCOND ? (ir[10:8] == 3'd0 ? UNCOND : COND) :
              ir[15:13] == OP_BCALL ? (ir[11] ? RET : CALL) : NONE;
    end
endmodule

// File: rtl/multi_bgu.sv
// multi_bgu: multi-lane bundle branch unit with static prediction, return-address stack
// and two-stage entry-offset lane masking.
module multi_bgu import kl_branch_pkg::*; #(
    parameter int LANES         = 2,
    parameter int PCW           = 9,
    parameter int RAS_DEPTH     = 4,
    parameter int PREDICT_TAKEN = 1,
    localparam int OW = $clog2(LANES),
    localparam int PW = $clog2(RAS_DEPTH),
    localparam int CW = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PCW-1:0]   pc,
    input  logic             fetch_next,
    input  logic [16*LANES-1:0] ir,
    input  logic [LANES-1:0] delayed_fmt,
    input  logic             redirect,
    input  logic [PCW-1:0]   redirect_pc,
    output logic [PCW-1:0]   pc_next,
    output logic [LANES-1:0] lane_valid,
    output logic             br_hit,
    output logic [OW-1:0]    br_lane,
    output logic [PCW-1:0]   delayed_dest,
    output logic [2:0]       delayed_cond,
    output logic             flush_s1,
    output logic             ras_underflow
);
    br_class_t      cls  [LANES];
    logic [PCW-1:0] fall [LANES];
    logic [PCW-1:0] tgt  [LANES];
    logic [2:0]     cnd  [LANES];
    logic [OW-1:0]  off_p1, entry_off;
    logic [PCW-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]  ptr, top_idx, nxt_ptr;
    logic [CW-1:0]  cnt;
    logic [PCW-1:0] now, raw_next;
    cond_pair_t     pair;
    logic           upd, push, pop;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_valid[k] = !flush_s1 && OW'(k) >= entry_off;
        branch_lane_decode #(.PCW(PCW), .K(k)) u_dec (
            .pc(pc), .ir(ir[16*k +: 16]), .fmt(delayed_fmt[k]), .valid(lane_valid[k]),
            .cls(cls[k]), .fall(fall[k]), .target(tgt[k]), .cond(cnd[k])
        );
    end

    // scan downward so the lowest branch lane wins
    always_comb begin
        br_hit  = 1'b0;
        br_lane = '0;
        for (int k = LANES - 1; k >= 0; k--)
            if (cls[k] != NONE) begin
                br_hit  = 1'b1;
                br_lane = OW'(k);
            end
    end

    assign top_idx = ptr == '0 ? PW'(RAS_DEPTH - 1) : ptr - 1'b1;
    assign nxt_ptr = ptr == PW'(RAS_DEPTH - 1) ? '0 : ptr + 1'b1;
    assign pair    = cond_pair(cnd[br_lane]);

    always_comb begin
        now          = pc + PCW'(LANES);
        delayed_dest = '0;
        delayed_cond = NV;
        if (br_hit) begin
            delayed_dest = fall[br_lane];
            case (cls[br_lane])
                COND: begin
                    now          = PREDICT_TAKEN != 0 ? tgt[br_lane] : fall[br_lane];
                    delayed_dest = PREDICT_TAKEN != 0 ? fall[br_lane] : tgt[br_lane];
                    delayed_cond = PREDICT_TAKEN != 0 ? pair.n : pair.c;
                end
                RET: begin
                    now          = cnt == '0 ? fall[br_lane] : ras[top_idx];
                    delayed_cond = AL;
                end
                default: now = tgt[br_lane];
            endcase
        end
    end

    assign raw_next = redirect ? redirect_pc : now;
    assign pc_next  = {raw_next[PCW-1:OW], OW'(0)};
    assign upd      = fetch_next && br_hit && !redirect;
    assign push     = upd && cls[br_lane] == CALL;
    assign pop      = upd && cls[br_lane] == RET && cnt != '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_s1      <= 1'b1;
            off_p1        <= '0;
            entry_off     <= '0;
            ptr           <= '0;
            cnt           <= '0;
            ras_underflow <= 1'b0;
        end else begin
            ras_underflow <= upd && cls[br_lane] == RET && cnt == '0;
            if (redirect) begin
                flush_s1  <= 1'b1;
                off_p1    <= redirect_pc[OW-1:0];
                entry_off <= '0;
            end else if (fetch_next) begin
                flush_s1  <= br_hit;
                off_p1    <= raw_next[OW-1:0];
                entry_off <= off_p1;
            end
            if (push) begin
                ptr <= nxt_ptr;
                cnt <= cnt == CW'(RAS_DEPTH) ? cnt : cnt + 1'b1;
            end else if (pop) begin
                ptr <= top_idx;
                cnt <= cnt - 1'b1;
            end
        end
    end

    // entries need no reset: an empty count makes them unreachable
    always_ff @(posedge clk)
        if (push) ras[ptr] <= fall[br_lane];
endmodule

// File: tb/tb_multi_bgu.sv
// tb_multi_bgu: directed self-checking bench for multi_bgu (LANES=2, PCW=9, RAS_DEPTH=4).
module tb_multi_bgu;
    logic       clk = 1'b0, rst = 1'b0;
    logic [8:0] pc = '0, redirect_pc = '0;
    logic       fetch_next = 1'b0, redirect = 1'b0;
    logic [31:0] ir = '0;
    logic [1:0] delayed_fmt = '0;
    logic [8:0] pc_next, delayed_dest;
    logic [1:0] lane_valid;
    logic       br_hit, br_lane, flush_s1, ras_underflow;
    logic [2:0] delayed_cond;
    int total = 0, bad = 0;

    multi_bgu #(.LANES(2), .PCW(9), .RAS_DEPTH(4), .PREDICT_TAKEN(1)) dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_next(fetch_next), .ir(ir),
        .delayed_fmt(delayed_fmt), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc_next(pc_next), .lane_valid(lane_valid), .br_hit(br_hit), .br_lane(br_lane),
        .delayed_dest(delayed_dest), .delayed_cond(delayed_cond), .flush_s1(flush_s1),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) step;
        total++; if (flush_s1 !== 1'b1) begin bad++; $display("FAIL rst_flush got=%0b exp=1", flush_s1); end
        total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL rst_underflow got=%0b exp=0", ras_underflow); end
        fetch_next = 1'b1;
        rst = 1'b1;
        #1;
        total++; if (lane_valid !== 2'b00) begin bad++; $display("FAIL first_lane_valid got=%b exp=00", lane_valid); end
        total++; if (pc_next !== 9'd2) begin bad++; $display("FAIL first_pc_next got=%0h exp=2", pc_next); end
        total++; if ({br_hit, br_lane, delayed_dest, delayed_cond} !== 14'd0) begin bad++; $display("FAIL nohit_outs got=%0b/%0b/%0h/%0d exp=0/0/0/0", br_hit, br_lane, delayed_dest, delayed_cond); end
        step;
        total++; if (lane_valid !== 2'b11) begin bad++; $display("FAIL run_lane_valid got=%b exp=11", lane_valid); end
    endtask

    task automatic test_cond;
        pc = 9'd4; ir = 32'h0000_2103; #1;
        total++; if (br_hit !== 1'b1 || br_lane !== 1'b0) begin bad++; $display("FAIL cond_hit got=%0b/%0b exp=1/0", br_hit, br_lane); end
        total++; if (pc_next !== 9'd8) begin bad++; $display("FAIL cond_pc_next got=%0h exp=8", pc_next); end
        total++; if (delayed_dest !== 9'd5) begin bad++; $display("FAIL cond_dd got=%0h exp=5", delayed_dest); end
        total++; if (delayed_cond !== 3'd3) begin bad++; $display("FAIL cond_dc got=%0d exp=3", delayed_cond); end
        step;
        pc = 9'd8; ir = '0; #1;
        total++; if (flush_s1 !== 1'b1 || lane_valid !== 2'b00) begin bad++; $display("FAIL cond_flush got=%0b/%b exp=1/00", flush_s1, lane_valid); end
        step;
        pc = 9'd4; delayed_fmt = 2'b01; ir = 32'h0000_2720; #1;
        total++; if (pc_next !== 9'h20) begin bad++; $display("FAIL abs_pc_next got=%0h exp=20", pc_next); end
        total++; if (delayed_dest !== 9'd5 || delayed_cond !== 3'd0) begin bad++; $display("FAIL abs_dd_dc got=%0h/%0d exp=5/0", delayed_dest, delayed_cond); end
        step;
        delayed_fmt = 2'b00; ir = '0; pc = 9'h20;
        step;
        total++; if (lane_valid !== 2'b11) begin bad++; $display("FAIL cond_recover got=%b exp=11", lane_valid); end
    endtask

    task automatic test_uncond_offset;
        pc = 9'd4; ir = 32'h2005_0000; #1;
        total++; if (br_hit !== 1'b1 || br_lane !== 1'b1) begin bad++; $display("FAIL unc_hit got=%0b/%0b exp=1/1", br_hit, br_lane); end
        total++; if (pc_next !== 9'd10) begin bad++; $display("FAIL unc_pc_next got=%0h exp=a", pc_next); end
        total++; if (delayed_dest !== 9'd6 || delayed_cond !== 3'd0) begin bad++; $display("FAIL unc_dd_dc got=%0h/%0d exp=6/0", delayed_dest, delayed_cond); end
        step;
        pc = 9'd10; ir = '0; #1;
        total++; if (lane_valid !== 2'b00) begin bad++; $display("FAIL unc_flush got=%b exp=00", lane_valid); end
        step;
        ir = 32'h0000_2103; #1;
        total++; if (lane_valid !== 2'b10) begin bad++; $display("FAIL unc_mask got=%b exp=10", lane_valid); end
        total++; if (br_hit !== 1'b0 || pc_next !== 9'd12) begin bad++; $display("FAIL masked_branch got=%0b/%0h exp=0/c", br_hit, pc_next); end
        step;
        ir = '0; #1;
        total++; if (lane_valid !== 2'b11) begin bad++; $display("FAIL unc_unmask got=%b exp=11", lane_valid); end
    endtask

    task automatic test_call_ret;
        pc = 9'd0; ir = 32'h0000_4010; #1;
        total++; if (pc_next !== 9'h10 || delayed_cond !== 3'd0) begin bad++; $display("FAIL call_pc_dc got=%0h/%0d exp=10/0", pc_next, delayed_cond); end
        step;
        ir = '0; pc = 9'h10;
        step;
        step;
        pc = 9'h20; ir = 32'h0000_4800; #1;
        total++; if (pc_next !== 9'h0) begin bad++; $display("FAIL ret_pc_next got=%0h exp=0", pc_next); end
        total++; if (delayed_cond !== 3'd1 || delayed_dest !== 9'h21) begin bad++; $display("FAIL ret_dc_dd got=%0d/%0h exp=1/21", delayed_cond, delayed_dest); end
        step;
        total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL ret_no_underflow got=%0b exp=0", ras_underflow); end
        ir = '0; pc = 9'h0;
        step;
        total++; if (lane_valid !== 2'b10) begin bad++; $display("FAIL ret_entry_off got=%b exp=10", lane_valid); end
        step;
    endtask

    task automatic test_ras_overflow;
        logic [8:0] exp_pc;
        for (int i = 1; i <= 5; i++) begin
            delayed_fmt = 2'b01; pc = 9'(i * 16); ir = 32'h0000_4080;
            step;
            ir = '0; pc = 9'h80;
            step;
        end
        delayed_fmt = 2'b00;
        for (int i = 0; i < 5; i++) begin
            pc = 9'h60; ir = 32'h0000_4800; #1;
            exp_pc = i < 4 ? 9'(9'h50 - i * 16) : 9'h60;
            total++; if (pc_next !== exp_pc) begin bad++; $display("FAIL ovf_ret%0d_pc got=%0h exp=%0h", i, pc_next, exp_pc); end
            total++; if (delayed_dest !== 9'h61 || delayed_cond !== 3'd1) begin bad++; $display("FAIL ovf_ret%0d_dd_dc got=%0h/%0d exp=61/1", i, delayed_dest, delayed_cond); end
            step;
            total++; if (ras_underflow !== (i == 4)) begin bad++; $display("FAIL ovf_ret%0d_underflow got=%0b exp=%0b", i, ras_underflow, i == 4); end
            ir = '0; pc = 9'h80;
            step;
            if (i == 4) begin
                total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL underflow_pulse got=%0b exp=0", ras_underflow); end
            end
            step;
        end
    endtask

    task automatic test_redirect;
        delayed_fmt = 2'b01; pc = 9'h10; ir = 32'h0000_4080;
        step;
        ir = '0; delayed_fmt = 2'b00;
        step;
        redirect = 1'b1; redirect_pc = 9'h23; fetch_next = 1'b0; pc = 9'h80; ir = 32'h0000_4800; #1;
        total++; if (pc_next !== 9'h22) begin bad++; $display("FAIL redir_pc_next got=%0h exp=22", pc_next); end
        step;
        redirect = 1'b0; ir = '0; #1;
        total++; if (flush_s1 !== 1'b1) begin bad++; $display("FAIL redir_flush got=%0b exp=1", flush_s1); end
        step;
        total++; if (flush_s1 !== 1'b1) begin bad++; $display("FAIL redir_hold got=%0b exp=1", flush_s1); end
        fetch_next = 1'b1;
        step;
        step;
        total++; if (lane_valid !== 2'b11) begin bad++; $display("FAIL redir_recover got=%b exp=11", lane_valid); end
        pc = 9'h40; ir = 32'h0000_4800; #1;
        total++; if (pc_next !== 9'h10) begin bad++; $display("FAIL redir_ras_kept got=%0h exp=10", pc_next); end
        step;
        ir = '0;
        step;
        step;
    endtask

    task automatic test_async_reset;
        delayed_fmt = 2'b01; pc = 9'h10; ir = 32'h0000_4080;
        step;
        ir = '0; delayed_fmt = 2'b00;
        step;
        #2 rst = 1'b0;
        #1;
        total++; if (flush_s1 !== 1'b1 || lane_valid !== 2'b00) begin bad++; $display("FAIL async_rst got=%0b/%b exp=1/00", flush_s1, lane_valid); end
        step;
        rst = 1'b1;
        step;
        pc = 9'h40; ir = 32'h0000_4800; #1;
        total++; if (pc_next !== 9'h40) begin bad++; $display("FAIL rst_ras_empty got=%0h exp=40", pc_next); end
        step;
        total++; if (ras_underflow !== 1'b1) begin bad++; $display("FAIL rst_underflow_pulse got=%0b exp=1", ras_underflow); end
        ir = '0;
        step;
    endtask

    initial begin
        test_reset;
        test_cond;
        test_uncond_offset;
        test_call_ret;
        test_ras_overflow;
        test_redirect;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
